// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding and lamp patterns shared by the intersection sequencer.
package traffic_pkg;
   typedef enum logic [2:0] {
      A_GREEN  = 3'd0,
      A_YELLOW = 3'd1,
      RED_AB   = 3'd2,
      B_GREEN  = 3'd3,
      B_YELLOW = 3'd4,
      RED_BA   = 3'd5
   } phase_t;
   // lamp bit order {ra, ya, ga, rb, yb, gb}
   localparam logic [5:0] L_A_GREEN  = 6'b001_100;
   localparam logic [5:0] L_A_YELLOW = 6'b010_100;
   localparam logic [5:0] L_ALL_RED  = 6'b100_100;
   localparam logic [5:0] L_B_GREEN  = 6'b100_001;
   localparam logic [5:0] L_B_YELLOW = 6'b100_010;
   function automatic logic [5:0] lamps_of(input phase_t p);
      case (p)
         A_YELLOW:       return L_A_YELLOW;
         RED_AB, RED_BA: return L_ALL_RED;
         B_GREEN:        return L_B_GREEN;
         B_YELLOW:       return L_B_YELLOW;
         default:        return L_A_GREEN;
      endcase
   endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating tick counter with synchronous clear (clear wins over enable).
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] t
);
   always_ff @(posedge clk or posedge reset)
      if (reset) t <= '0;
      else if (clr) t <= '0;
      else if (en && t != '1) t <= t + 1'b1;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: actuated two-approach signal sequencer with min/max green, yellow and all-red.
// Define EMERG_PREEMPT_EN to add the preempt/preempt_b emergency override inputs.
module traffic_phase_scheduler #(
   parameter int MIN_GREEN    = 8,
   parameter int MAX_GREEN    = 30,
   parameter int YELLOW_TIME  = 3,
   parameter int ALL_RED_TIME = 1,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       sa,
   input  logic       sb,
`ifdef EMERG_PREEMPT_EN
   input  logic       preempt,
   input  logic       preempt_b,
`endif
   output logic       ra,
   output logic       ya,
   output logic       ga,
   output logic       rb,
   output logic       yb,
   output logic       gb,
   output logic [2:0] phase,
   output logic       req_a_pend,
   output logic       req_b_pend
);
   import traffic_pkg::*;
   localparam logic [CNT_W-1:0] MG = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MX = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] YT = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] AR = CNT_W'(ALL_RED_TIME - 1);
   localparam phase_t AFTER_AY = (ALL_RED_TIME == 0) ? B_GREEN : RED_AB;
   localparam phase_t AFTER_BY = (ALL_RED_TIME == 0) ? A_GREEN : RED_BA;
   phase_t st, nxt;
   logic [CNT_W-1:0] t;
   logic pre_a, pre_b, exit_a, exit_b;
`ifdef EMERG_PREEMPT_EN
   assign pre_a = preempt && !preempt_b;
   assign pre_b = preempt && preempt_b;
`else
   assign pre_a = 1'b0;
   assign pre_b = 1'b0;
`endif
   // the serving sensor only delays gap-out; exit needs an opposing request
   assign exit_a = pre_b || (!pre_a && req_b_pend && t >= MG && (!sa || t >= MX));
   assign exit_b = pre_a || (!pre_b && req_a_pend && t >= MG && (!sb || t >= MX));
   always_comb
      case (st)
         A_GREEN:  nxt = (tick && exit_a)  ? A_YELLOW : A_GREEN;
         A_YELLOW: nxt = (tick && t == YT) ? AFTER_AY : A_YELLOW;
         RED_AB:   nxt = (tick && t == AR) ? B_GREEN  : RED_AB;
         B_GREEN:  nxt = (tick && exit_b)  ? B_YELLOW : B_GREEN;
         B_YELLOW: nxt = (tick && t == YT) ? AFTER_BY : B_YELLOW;
         RED_BA:   nxt = (tick && t == AR) ? A_GREEN  : RED_BA;
         default:  nxt = A_GREEN;
      endcase
   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk(clk),
      .reset(reset),
      .clr(nxt != st),
      .en(tick),
      .t(t)
   );
   // lamps decode the next state so they switch on the same edge as phase
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st <= A_GREEN;
         {ra, ya, ga, rb, yb, gb} <= L_A_GREEN;
         req_a_pend <= 1'b0;
         req_b_pend <= 1'b0;
      end else begin
         st <= nxt;
         {ra, ya, ga, rb, yb, gb} <= lamps_of(nxt);
         req_a_pend <= (nxt == A_GREEN && st != A_GREEN) ? 1'b0 : (sa && st != A_GREEN) ? 1'b1 : req_a_pend;
         req_b_pend <= (nxt == B_GREEN && st != B_GREEN) ? 1'b0 : (sb && st != B_GREEN) ? 1'b1 : req_b_pend;
      end
   assign phase = st;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed checks of timing, actuation and reset; a second instance covers ALL_RED_TIME=0.
module tb_traffic_phase_scheduler;
   localparam logic [8:0] S_AG  = {3'd0, 6'b001_100};
   localparam logic [8:0] S_AY  = {3'd1, 6'b010_100};
   localparam logic [8:0] S_RAB = {3'd2, 6'b100_100};
   localparam logic [8:0] S_BG  = {3'd3, 6'b100_001};
   localparam logic [8:0] S_BY  = {3'd4, 6'b100_010};
   logic clk, reset, tick, sa, sb;
   logic ra, ya, ga, rb, yb, gb, pa, pb;
   logic ra0, ya0, ga0, rb0, yb0, gb0, pa0, pb0;
   logic [2:0] phase, phase0;
   logic [8:0] s1, s0, pend;
   logic saw0 = 1'b0;
   int checks = 0;
   int errors = 0;
`ifdef EMERG_PREEMPT_EN
   logic preempt, preempt_b;
`endif
   traffic_phase_scheduler dut (
      .clk(clk), .reset(reset), .tick(tick), .sa(sa), .sb(sb),
`ifdef EMERG_PREEMPT_EN
      .preempt(preempt), .preempt_b(preempt_b),
`endif
      .ra(ra), .ya(ya), .ga(ga), .rb(rb), .yb(yb), .gb(gb),
      .phase(phase), .req_a_pend(pa), .req_b_pend(pb)
   );
   traffic_phase_scheduler #(.ALL_RED_TIME(0)) dut0 (
      .clk(clk), .reset(reset), .tick(tick), .sa(sa), .sb(sb),
`ifdef EMERG_PREEMPT_EN
      .preempt(preempt), .preempt_b(preempt_b),
`endif
      .ra(ra0), .ya(ya0), .ga(ga0), .rb(rb0), .yb(yb0), .gb(gb0),
      .phase(phase0), .req_a_pend(pa0), .req_b_pend(pb0)
   );
   assign s1 = {phase, ra, ya, ga, rb, yb, gb};
   assign s0 = {phase0, ra0, ya0, ga0, rb0, yb0, gb0};
   assign pend = {7'd0, pa, pb};
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // the zero-all-red build must never show both reds together
   always @(negedge clk) if (ra0 && rb0) saw0 <= 1'b1;
   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tk();
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      @(posedge clk); #1;
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tk();
   endtask
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask
   initial begin
      reset = 1'b1; tick = 1'b0; sa = 1'b0; sb = 1'b0;
`ifdef EMERG_PREEMPT_EN
      preempt = 1'b0; preempt_b = 1'b0;
`endif
      @(posedge clk); #1;
      chk("rst_state", s1, S_AG);
      chk("rst_pend", pend, 9'd0);
      chk("rst_state0", s0, S_AG);
      chk("rst_pend0", {7'd0, pa0, pb0}, 9'd0);
      reset = 1'b0;
      tk();
      sb = 1'b1; tk(); sb = 1'b0;
      chk("t2_latch", pend, 9'd1);
      ticks(5);
      chk("t2_min_hold", s1, S_AG);
      tk();
      chk("t2_yellow", s1, S_AY);
      chk("t2_yellow0", s0, S_AY);
      ticks(2);
      chk("t2_yellow_hold", s1, S_AY);
      tk();
      chk("t2_allred", s1, S_RAB);
      chk("t5_skip_red0", s0, S_BG);
      tk();
      chk("t2_bgreen", s1, S_BG);
      chk("t2_bclr", pend, 9'd0);
      sa = 1'b1; tk(); sa = 1'b0;
      chk("t2_alatch", pend, 9'd2);
      ticks(6);
      chk("t2_bhold", s1, S_BG);
      tk();
      chk("t2_byellow", s1, S_BY);
      tk();
      reset = 1'b1; #1;
      chk("t1_async", s1, S_AG);
      chk("t1_async_pend", pend, 9'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      ticks(100);
      chk("t1_rest", s1, S_AG);
      chk("t1_rest_pend", pend, 9'd0);
      sa = 1'b1; sb = 1'b1;
      do_reset();
      ticks(29);
      chk("t3_a29", s1, S_AG);
      chk("t3_pend", pend, 9'd1);
      tk();
      chk("t3_amax", s1, S_AY);
      ticks(3);
      chk("t3_allred", s1, S_RAB);
      tk();
      chk("t3_bgreen", s1, S_BG);
      chk("t3_bpend", pend, 9'd2);
      ticks(29);
      chk("t3_b29", s1, S_BG);
      tk();
      chk("t3_bmax", s1, S_BY);
      do_reset();
      ticks(15);
      chk("t4_a15", s1, S_AG);
      sa = 1'b0;
      tk();
      chk("t4_gapout", s1, S_AY);
`ifdef EMERG_PREEMPT_EN
      sa = 1'b1; sb = 1'b0;
      do_reset();
      ticks(2);
      preempt = 1'b1; preempt_b = 1'b1;
      tk();
      chk("t6_force_yellow", s1, S_AY);
      ticks(3);
      chk("t6_allred", s1, S_RAB);
      tk();
      chk("t6_bgreen", s1, S_BG);
      ticks(35);
      chk("t6_hold", s1, S_BG);
      preempt = 1'b0;
      tk();
      chk("t6_release", s1, S_BY);
`endif
      chk("t5_no_allred0", {8'd0, saw0}, 9'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
